mux421_arbiter: RTL and testbench
=================================

# mux421_arbiter

Round-robin arbiter and select controller for the 4:1 one-bit mux. Four requesters compete for the single mux output; the block grants one at a time, drives the mux `sel[1:0]` with the owner's index, and bounds each ownership with a hold limit so no requester can starve the others. It sits directly in front of `MUX421` and is the only driver of its select lines.

## Interface
- `MAX_HOLD`, 8: maximum consecutive grant cycles per ownership; legal range 1..255.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `req`  in  4  request per mux input; `req[i]` asks for mux input `in[i]`; level-sensitive.
- `gnt`  out  4  one-hot grant, registered; all zero when idle.
- `sel`  out  2  mux select, registered; binary index of the current or most recent owner.
- `busy`  out  1  high while a grant is active; equals `|gnt`.
- `preempt`  out  1  one-cycle pulse when a grant is forcibly ended by the hold limit.

## Operation
- Two states: IDLE and GRANT.
- Round-robin pointer `last[1:0]` holds the index of the previous owner. Search order is `last+1, last+2, last+3, last`, all modulo 4, with wrap from 3 to 0.
- IDLE: if `req != 0`, pick the first set bit in search order, load `gnt`, `sel` and `last` with it, set `hold_cnt = 1`, and go to GRANT. If `req == 0`, stay in IDLE with `gnt = 0` and `sel` unchanged.
- GRANT, owner `o`:
  - Release: if `req[o] == 0`, clear `gnt`, clear `hold_cnt`, go to IDLE.
  - Forced release: else if `hold_cnt == MAX_HOLD`, clear `gnt`, pulse `preempt`, go to IDLE.
  - Otherwise: increment `hold_cnt` and keep `gnt` and `sel`.
- Requests from non-owners during GRANT are ignored. They are evaluated at the next IDLE cycle.
- Because `last = o` after a release, the previous owner has the lowest priority at the next arbitration. If it is the only requester, it is re-granted.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`. It never exceeds `MAX_HOLD` and never wraps.
- Reset values: `gnt = 0`, `sel = 0`, `busy = 0`, `preempt = 0`, state IDLE, `last = 3` (so `req[0]` has top priority first), `hold_cnt = 0`.
- Reset during GRANT takes effect at that edge. All outputs return to their reset values and any in-flight ownership is dropped without a `preempt` pulse.
- Mux output is meaningful only while `busy == 1`. `sel` holding its last value while idle is intentional and avoids select glitches.

## Timing
- Grant latency: `req` sampled high in IDLE at edge n gives `gnt`/`sel`/`busy` valid after edge n.
- Release latency: owner `req` sampled low at edge m gives `gnt = 0` after edge m. A minimum of one IDLE cycle separates any two grants.
- Maximum ownership: `MAX_HOLD` cycles with `gnt` high. `preempt` is high in the first IDLE cycle after a forced release and for one cycle only.
- Worst-case wait for a continuously requesting input: 3 × (`MAX_HOLD` + 1) cycles.
- `sel` and `gnt` change on the same edge, so the mux select never disagrees with the grant.
- Owner deasserting `req` on the same edge that `hold_cnt == MAX_HOLD`: treated as a normal release, with `preempt` staying 0.

## Structure
- Shared package `mux421_pkg`:
  - `NUM_REQ = 4`
  - state encoding: IDLE = 0, GRANT = 1
  - `SEL_W = 2`
- Sub-module `rr_pick4`: purely combinational. Inputs are `req[3:0]` and `last[1:0]`. Outputs are `found` and `idx[1:0]` in the search order above. The arbiter FSM, `hold_cnt` and output registers live in `mux421_arbiter`.
- Bench instantiates `mux421_arbiter` driving `MUX421` and checks that `out == in[sel]` whenever `busy`.

## Test plan
- Reset then `req = 4'b1111` held: grants in order 0,1,2,3,0. Each lasts 8 cycles, `preempt` pulses after each, with one IDLE cycle between grants.
- `req = 4'b0100` for 3 cycles, then 0: `gnt = 4'b0100`, `sel = 2`, `busy` for 3 cycles. Then `gnt = 0`, `sel` stays 2, `preempt` stays 0.
- Single requester `req = 4'b0010` held, with `MAX_HOLD = 2`: pattern is grant, grant, idle (`preempt = 1`), grant, and so on. `sel = 1` throughout.
- Owner 3 releases on the same edge its `hold_cnt` hits `MAX_HOLD`, while `req[0]` is high: `preempt = 0`, next grant goes to 0 (wrap from `last = 3`).
- `rst` asserted mid-grant with owner 2: after that edge all outputs are 0, state is IDLE. With `req = 4'b0101`, the next grant goes to 0.
- Datapath check: `in = 4'b1010` with random `req` over 200 cycles gives `out == in[sel]` on every `busy` cycle and `gnt` is always one-hot or zero.

Source files
------------

// File: rtl/mux421_pkg.sv
// rtl/mux421_pkg.sv - shared constants and state encoding for the 4:1 mux select arbiter
package mux421_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick of the first request after last
module rr_pick4
    import mux421_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // k = 4 lands back on last itself, so the previous owner is searched last
    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last + SEL_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux421_arbiter.sv
// rtl/mux421_arbiter.sv - round-robin arbiter with hold limit driving the 4:1 mux select
module mux421_arbiter
    import mux421_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               preempt
);

    localparam int                CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  HOLD_LIM = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [SEL_W-1:0] last;
    logic [CNT_W-1:0] hold_cnt;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // sel is left alone when going idle so the mux select never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            last     <= SEL_W'(NUM_REQ - 1);
            hold_cnt <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        gnt      <= NUM_REQ'(1) << pick_idx;
                        sel      <= pick_idx;
                        last     <= pick_idx;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!req[sel]) begin
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LIM) begin
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        preempt  <= 1'b1;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux421_arbiter.sv
// tb/tb_mux421_arbiter.sv - directed vector bench for mux421_arbiter with a behavioural 4:1 mux
module tb_mux421_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1;
    logic       rst2 = 1'b1;
    logic [3:0] req8 = 4'b0;
    logic [3:0] req2 = 4'b0;
    logic [3:0] gnt8, gnt2;
    logic [1:0] sel8, sel2;
    logic       busy8, busy2, pre8, pre2;
    logic [3:0] mux_in = 4'b0;
    logic       mux_out;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign mux_out = mux_in[sel8];

    mux421_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk     (clk),
        .rst     (rst8),
        .req     (req8),
        .gnt     (gnt8),
        .sel     (sel8),
        .busy    (busy8),
        .preempt (pre8)
    );

    mux421_arbiter #(.MAX_HOLD(2)) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .req     (req2),
        .gnt     (gnt2),
        .sel     (sel2),
        .busy    (busy2),
        .preempt (pre2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g,
                       input logic [1:0] s, input logic b, input logic p);
        vec_t v;
        v.rst = r; v.req = q; v.gnt = g; v.sel = s; v.busy = b; v.pre = p;
        vecs.push_back(v);
    endtask

    initial begin
        int gidx;

        // reset
        add(1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);
        // all four requesting: owners 0,1,2,3,0, eight cycles each, preempt idle between
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++)
                add(1'b0, 4'hF, 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
            add(1'b0, 4'hF, 4'h0, 2'(g % 4), 1'b0, 1'b1);
        end
        // requester 2 for three cycles then voluntary release, sel holds 2
        for (int c = 0; c < 3; c++) add(1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0);
        add(1'b0, 4'h0, 4'h0, 2'd2, 1'b0, 1'b0);
        // reset in the middle of owner 2, then 0 wins from last = 3
        add(1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0);
        add(1'b0, 4'h4, 4'h4, 2'd2, 1'b1, 1'b0);
        add(1'b1, 4'h4, 4'h0, 2'd0, 1'b0, 1'b0);
        add(1'b0, 4'h5, 4'h1, 2'd0, 1'b1, 1'b0);
        add(1'b1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            rst8 = vecs[i].rst;
            req8 = vecs[i].req;
            tick();
            chk($sformatf("v%0d.gnt", i),  32'(gnt8),  32'(vecs[i].gnt));
            chk($sformatf("v%0d.sel", i),  32'(sel8),  32'(vecs[i].sel));
            chk($sformatf("v%0d.busy", i), 32'(busy8), 32'(vecs[i].busy));
            chk($sformatf("v%0d.pre", i),  32'(pre8),  32'(vecs[i].pre));
        end
        rst8 = 1'b0;

        // owner 3 drops req on the same edge its hold count reaches the limit
        req8 = 4'h8;
        tick();
        chk("own3.gnt", 32'(gnt8), 32'h8);
        chk("own3.sel", 32'(sel8), 32'd3);
        req8 = 4'h9;
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk($sformatf("own3.hold%0d", c), 32'(gnt8), 32'h8);
        end
        req8 = 4'h1;
        tick();
        chk("own3.rel_gnt", 32'(gnt8), 32'h0);
        chk("own3.rel_pre", 32'(pre8), 32'h0);
        chk("own3.rel_sel", 32'(sel8), 32'd3);
        tick();
        chk("wrap.gnt", 32'(gnt8), 32'h1);
        chk("wrap.sel", 32'(sel8), 32'd0);
        req8 = 4'h0;
        tick();

        // MAX_HOLD = 2 with a lone requester 1: grant, grant, preempt idle, repeat
        tick();
        rst2 = 1'b0;
        req2 = 4'h2;
        for (int c = 0; c < 9; c++) begin
            tick();
            chk($sformatf("h2.c%0d.gnt", c),  32'(gnt2),  (c % 3 == 2) ? 32'h0 : 32'h2);
            chk($sformatf("h2.c%0d.pre", c),  32'(pre2),  (c % 3 == 2) ? 32'h1 : 32'h0);
            chk($sformatf("h2.c%0d.busy", c), 32'(busy2), (c % 3 == 2) ? 32'h0 : 32'h1);
            chk($sformatf("h2.c%0d.sel", c),  32'(sel2),  32'd1);
        end
        req2 = 4'h0;

        // random requests through the mux with in = 1010
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        mux_in = 4'b1010;
        for (int c = 0; c < 200; c++) begin
            req8 = 4'($urandom_range(0, 15));
            tick();
            chk($sformatf("rnd%0d.onehot", c), 32'($countones(gnt8) <= 1), 32'd1);
            chk($sformatf("rnd%0d.busy", c), 32'(busy8), 32'(|gnt8));
            if (busy8) begin
                gidx = 0;
                for (int k = 0; k < 4; k++) if (gnt8[k]) gidx = k;
                chk($sformatf("rnd%0d.mux", c), 32'(mux_out), 32'(mux_in[gidx]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
